// File: rtl/fifo_pair_compare_ctrl_if.sv
// Read-side bundle between the compare sequencer and the two capture FIFOs.
interface fifo_pair_compare_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int USEDW_W = 11
);
    logic               a_rdempty;
    logic               b_rdempty;
    logic [USEDW_W-1:0] a_rdusedw;
    logic [USEDW_W-1:0] b_rdusedw;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               a_rdreq;
    logic               b_rdreq;

    modport master (
        input  a_rdempty, b_rdempty, a_rdusedw, b_rdusedw, a_q, b_q,
        output a_rdreq, b_rdreq
    );

    modport slave (
        output a_rdempty, b_rdempty, a_rdusedw, b_rdusedw, a_q, b_q,
        input  a_rdreq, b_rdreq
    );
endinterface

// File: rtl/fifo_pair_compare_ctrl.sv
// Lockstep drain-and-compare sequencer for the bus A / bus B capture FIFOs.
//
// state  | meaning
// IDLE   | stopped, waiting for enable
// WAIT   | waiting for a full frame in both FIFOs, skew timer running
// READ   | FRAME_LEN lockstep reads from both FIFOs
// DRAIN  | no reads; last read word is compared
// REPORT | frame_done pulse, verdict valid
// FLUSH  | FRAME_LEN reads from the leading FIFO only, data discarded
module fifo_pair_compare_ctrl #(
    parameter int DATA_W       = 8,
    parameter int USEDW_W      = 11,
    parameter int FRAME_LEN    = 16,
    parameter int SKEW_TIMEOUT = 1024,
    parameter int STAT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    fifo_pair_compare_ctrl_if.master       fifo,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           frame_match,
    output logic [$clog2(FRAME_LEN+1)-1:0] frame_mis_cnt,
    output logic [$clog2(FRAME_LEN)-1:0]   first_mis_idx,
    output logic [DATA_W-1:0]              first_mis_a,
    output logic [DATA_W-1:0]              first_mis_b,
    output logic                           skew_err,
    output logic [STAT_W-1:0]              frames_total,
    output logic [STAT_W-1:0]              frames_bad,
    output logic [STAT_W-1:0]              skew_events
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int MIS_W = $clog2(FRAME_LEN + 1);
    localparam int TMR_W = (SKEW_TIMEOUT > 2) ? $clog2(SKEW_TIMEOUT) : 1;

    localparam logic [USEDW_W-1:0] FRAME_LEN_U = USEDW_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0]   RD_LOAD     = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(SKEW_TIMEOUT - 1);
    localparam logic [STAT_W-1:0]  STAT_MAX    = {STAT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_REPORT,
        S_FLUSH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start_read;
    logic              start_flush;
    logic              a_rdy;
    logic              b_rdy;
    logic [IDX_W-1:0]  rd_cnt;
    logic [TMR_W-1:0]  skew_tmr;
    logic              flush_a;
    logic              cmp_vld;
    logic [IDX_W-1:0]  cmp_idx;
    logic              mis_hit;
    logic              have_result;

    // rdusedw only ever under-reports, so a full frame here is safe to read blind
    assign a_rdy   = !fifo.a_rdempty && (fifo.a_rdusedw >= FRAME_LEN_U);
    assign b_rdy   = !fifo.b_rdempty && (fifo.b_rdusedw >= FRAME_LEN_U);
    assign mis_hit = cmp_vld && (fifo.a_q != fifo.b_q);

    assign busy         = (state != S_IDLE);
    assign frame_done   = (state == S_REPORT);
    assign frame_match  = have_result && (frame_mis_cnt == '0);
    assign fifo.a_rdreq = (state == S_READ) || ((state == S_FLUSH) && flush_a);
    assign fifo.b_rdreq = (state == S_READ) || ((state == S_FLUSH) && !flush_a);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; READ takes priority over a timer expiring on the same cycle
    always_comb begin
        state_nxt   = state;
        start_read  = 1'b0;
        start_flush = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (a_rdy && b_rdy) begin
                    state_nxt  = S_READ;
                    start_read = 1'b1;
                end else if ((a_rdy ^ b_rdy) && (skew_tmr == TMR_LAST)) begin
                    state_nxt   = S_FLUSH;
                    start_flush = 1'b1;
                end
            end
            S_READ:   if (rd_cnt == '0) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_REPORT;
            S_REPORT: state_nxt = S_WAIT;
            S_FLUSH:  if (rd_cnt == '0) state_nxt = S_WAIT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Read-burst down-counter shared by READ and FLUSH, plus the flush side select
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            flush_a <= 1'b0;
        end else begin
            if (start_read || start_flush)
                rd_cnt <= RD_LOAD;
            else if (((state == S_READ) || (state == S_FLUSH)) && (rd_cnt != '0))
                rd_cnt <= rd_cnt - IDX_W'(1);
            if (start_flush)
                flush_a <= a_rdy;
        end
    end

    // Skew timer counts only while exactly one side holds a frame in WAIT
    always_ff @(posedge clk) begin
        if (rst)
            skew_tmr <= '0;
        else if ((state == S_WAIT) && enable && (a_rdy ^ b_rdy) && !start_flush)
            skew_tmr <= skew_tmr + TMR_W'(1);
        else
            skew_tmr <= '0;
    end

    // Compare pipeline: q is valid the cycle after rdreq in a non-show-ahead FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld       <= 1'b0;
            cmp_idx       <= '0;
            frame_mis_cnt <= '0;
            first_mis_idx <= '0;
            first_mis_a   <= '0;
            first_mis_b   <= '0;
            have_result   <= 1'b0;
        end else begin
            cmp_vld <= (state == S_READ);
            if (start_read) begin
                cmp_idx       <= '0;
                frame_mis_cnt <= '0;
                first_mis_idx <= '0;
                first_mis_a   <= '0;
                first_mis_b   <= '0;
                have_result   <= 1'b0;
            end else begin
                if (cmp_vld) begin
                    cmp_idx <= cmp_idx + IDX_W'(1);
                    if (mis_hit) begin
                        frame_mis_cnt <= frame_mis_cnt + MIS_W'(1);
                        if (frame_mis_cnt == '0) begin
                            first_mis_idx <= cmp_idx;
                            first_mis_a   <= fifo.a_q;
                            first_mis_b   <= fifo.b_q;
                        end
                    end
                end
                if (state == S_DRAIN)
                    have_result <= 1'b1;
            end
        end
    end

    // Statistics; frame counters step leaving DRAIN so they are current while frame_done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_total <= '0;
            frames_bad   <= '0;
            skew_events  <= '0;
            skew_err     <= 1'b0;
        end else begin
            skew_err <= start_flush;
            if (start_flush && (skew_events != STAT_MAX))
                skew_events <= skew_events + STAT_W'(1);
            if (state == S_DRAIN) begin
                if (frames_total != STAT_MAX)
                    frames_total <= frames_total + STAT_W'(1);
                if (((frame_mis_cnt != '0) || mis_hit) && (frames_bad != STAT_MAX))
                    frames_bad <= frames_bad + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pair_compare_ctrl.sv
// Scenario bench for fifo_pair_compare_ctrl with behavioural FIFOs and a frame-level reference.
module tb_fifo_pair_compare_ctrl;
    localparam int FL       = 16;
    localparam int ST       = 8;
    localparam int SW       = 2;
    localparam int DW       = 8;
    localparam int UW       = 11;
    localparam int STAT_MAX = (1 << SW) - 1;

    typedef logic [7:0] frame_t [FL];
    typedef struct {
        int cyc; int match; int mis; int idx; int fa; int fb; int tot; int bad;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy, frame_done, frame_match, skew_err;
    logic [$clog2(FL+1)-1:0] frame_mis_cnt;
    logic [$clog2(FL)-1:0]   first_mis_idx;
    logic [DW-1:0]           first_mis_a, first_mis_b;
    logic [SW-1:0]           frames_total, frames_bad, skew_events;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_pair_compare_ctrl_if #(.DATA_W(DW), .USEDW_W(UW)) f ();

    fifo_pair_compare_ctrl #(
        .DATA_W(DW), .USEDW_W(UW), .FRAME_LEN(FL), .SKEW_TIMEOUT(ST), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo(f),
        .busy(busy), .frame_done(frame_done), .frame_match(frame_match),
        .frame_mis_cnt(frame_mis_cnt), .first_mis_idx(first_mis_idx),
        .first_mis_a(first_mis_a), .first_mis_b(first_mis_b), .skew_err(skew_err),
        .frames_total(frames_total), .frames_bad(frames_bad), .skew_events(skew_events)
    );

    // Behavioural non-show-ahead FIFOs: pointers, data one cycle after rdreq
    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];
    int wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;
    int underflows = 0;

    always @(posedge clk) begin
        if (f.a_rdreq) begin
            if (wr_a != rd_a) begin f.a_q <= mem_a[rd_a % 1024]; rd_a = rd_a + 1; end
            else underflows = underflows + 1;
        end
        if (f.b_rdreq) begin
            if (wr_b != rd_b) begin f.b_q <= mem_b[rd_b % 1024]; rd_b = rd_b + 1; end
            else underflows = underflows + 1;
        end
        f.a_rdusedw <= UW'(wr_a - rd_a);
        f.b_rdusedw <= UW'(wr_b - rd_b);
        f.a_rdempty <= (wr_a == rd_a);
        f.b_rdempty <= (wr_b == rd_b);
    end

    // Event monitor, sampled mid-cycle
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t done_q[$];
    int   rise_q[$];
    int   skew_q[$];
    int   onerdy_q[$];
    int   ra_cnt = 0, rb_cnt = 0, long_done = 0, long_skew = 0;
    bit   prev_a = 0, prev_one = 0, prev_done = 0, prev_skew = 0;

    always @(negedge clk) begin
        rec_t r;
        bit one;
        if (f.a_rdreq === 1'b1) ra_cnt++;
        if (f.b_rdreq === 1'b1) rb_cnt++;
        if (f.a_rdreq === 1'b1 && !prev_a) rise_q.push_back(cyc);
        prev_a = (f.a_rdreq === 1'b1);
        if (frame_done === 1'b1) begin
            r.cyc = cyc; r.match = int'(frame_match); r.mis = int'(frame_mis_cnt);
            r.idx = int'(first_mis_idx); r.fa = int'(first_mis_a); r.fb = int'(first_mis_b);
            r.tot = int'(frames_total); r.bad = int'(frames_bad);
            done_q.push_back(r);
            if (prev_done) long_done++;
        end
        prev_done = (frame_done === 1'b1);
        if (skew_err === 1'b1) begin
            skew_q.push_back(cyc);
            if (prev_skew) long_skew++;
        end
        prev_skew = (skew_err === 1'b1);
        one = ((f.a_rdempty === 1'b0) && (int'(f.a_rdusedw) >= FL)) ^
              ((f.b_rdempty === 1'b0) && (int'(f.b_rdusedw) >= FL));
        if (one && !prev_one) onerdy_q.push_back(cyc);
        prev_one = one;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: verdict for one frame from plain byte comparison
    task automatic ref_frame(input frame_t a, input frame_t b,
                             output int mis, output int idx, output int fa, output int fb);
        mis = 0; idx = 0; fa = 0; fb = 0;
        for (int i = 0; i < FL; i++) begin
            if (a[i] != b[i]) begin
                if (mis == 0) begin idx = i; fa = int'(a[i]); fb = int'(b[i]); end
                mis++;
            end
        end
    endtask

    task automatic push_frame(input frame_t a, input frame_t b, input bit do_a, input bit do_b);
        for (int i = 0; i < FL; i++) begin
            if (do_a) begin mem_a[wr_a % 1024] = a[i]; wr_a++; end
            if (do_b) begin mem_b[wr_b % 1024] = b[i]; wr_b++; end
        end
    endtask

    task automatic rand_frame(output frame_t a);
        for (int i = 0; i < FL; i++) a[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        enable = 0;
        @(negedge clk); rst = 1;
        @(negedge clk);
        wr_a = rd_a; wr_b = rd_b;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && done_q.size() < target; i++) @(negedge clk);
        @(negedge clk);
        ok = (done_q.size() >= target);
    endtask

    task automatic wait_rdreq(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (f.a_rdreq === 1'b1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if ({busy, f.a_rdreq, f.b_rdreq, frame_done, frame_match, skew_err} !== 6'b0) begin miscompares++; $display("FAIL rst_flags: got %b expected 000000", {busy, f.a_rdreq, f.b_rdreq, frame_done, frame_match, skew_err}); end
        vectors++; if (frame_mis_cnt !== '0 || first_mis_idx !== '0) begin miscompares++; $display("FAIL rst_result_cnt: got %0d/%0d expected 0/0", frame_mis_cnt, first_mis_idx); end
        vectors++; if ({first_mis_a, first_mis_b} !== 16'h0) begin miscompares++; $display("FAIL rst_result_bytes: got %h expected 0000", {first_mis_a, first_mis_b}); end
        vectors++; if ({frames_total, frames_bad, skew_events} !== 6'b0) begin miscompares++; $display("FAIL rst_stats: got %b expected 000000", {frames_total, frames_bad, skew_events}); end
        rst = 0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_without_enable: busy got %b expected 0", busy); end
    endtask

    task automatic test_equal_frame();
        frame_t a; int n0, r0, ca, cb; bit ok; rec_t r;
        do_reset();
        for (int i = 0; i < FL; i++) a[i] = 8'(i);
        n0 = done_q.size(); r0 = rise_q.size(); ca = ra_cnt; cb = rb_cnt;
        push_frame(a, a, 1, 1);
        enable = 1;
        wait_done(n0 + 1, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL eq_done_timeout: frames got %0d expected %0d", done_q.size() - n0, 1); end
        else begin
            r = done_q[n0];
            vectors++; if (r.cyc - rise_q[r0] !== FL + 1) begin miscompares++; $display("FAIL eq_latency: got %0d expected %0d", r.cyc - rise_q[r0], FL + 1); end
            vectors++; if (ra_cnt - ca !== FL || rb_cnt - cb !== FL) begin miscompares++; $display("FAIL eq_rdreq_cycles: got %0d/%0d expected %0d", ra_cnt - ca, rb_cnt - cb, FL); end
            vectors++; if (r.match !== 1 || r.mis !== 0) begin miscompares++; $display("FAIL eq_verdict: got match=%0d mis=%0d expected 1/0", r.match, r.mis); end
            vectors++; if (r.idx !== 0 || r.fa !== 0 || r.fb !== 0) begin miscompares++; $display("FAIL eq_first_fields: got %0d %0h %0h expected 0 0 0", r.idx, r.fa, r.fb); end
            vectors++; if (r.tot !== 1 || r.bad !== 0) begin miscompares++; $display("FAIL eq_stats: got %0d/%0d expected 1/0", r.tot, r.bad); end
        end
    endtask

    task automatic test_mismatch();
        frame_t a, b; int n0, mis, idx, fa, fb; bit ok; rec_t r;
        do_reset();
        for (int i = 0; i < FL; i++) a[i] = 8'(i);
        b = a; b[5] = 8'hAA; b[12] = 8'h00;
        ref_frame(a, b, mis, idx, fa, fb);
        n0 = done_q.size();
        push_frame(a, b, 1, 1);
        enable = 1;
        wait_done(n0 + 1, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL mis_done_timeout: frames got %0d expected 1", done_q.size() - n0); end
        else begin
            r = done_q[n0];
            vectors++; if (r.match !== 0 || r.mis !== mis) begin miscompares++; $display("FAIL mis_verdict: got match=%0d mis=%0d expected 0/%0d", r.match, r.mis, mis); end
            vectors++; if (r.idx !== idx || r.fa !== fa || r.fb !== fb) begin miscompares++; $display("FAIL mis_first: got %0d %0h %0h expected %0d %0h %0h", r.idx, r.fa, r.fb, idx, fa, fb); end
            vectors++; if (r.tot !== 1 || r.bad !== 1) begin miscompares++; $display("FAIL mis_stats: got %0d/%0d expected 1/1", r.tot, r.bad); end
            repeat (5) @(negedge clk);
            vectors++; if (int'(first_mis_idx) !== idx || int'(frame_mis_cnt) !== mis || frame_match !== 1'b0) begin miscompares++; $display("FAIL mis_hold: got %0d/%0d/%b expected %0d/%0d/0", first_mis_idx, frame_mis_cnt, frame_match, idx, mis); end
        end
    endtask

    task automatic test_skew();
        frame_t a; int n0, s0, o0, ca, cb;
        do_reset();
        enable = 1;
        repeat (3) @(negedge clk);
        rand_frame(a);
        n0 = done_q.size(); s0 = skew_q.size(); o0 = onerdy_q.size(); ca = ra_cnt; cb = rb_cnt;
        push_frame(a, a, 1, 0);
        for (int i = 0; i < 100 && skew_q.size() <= s0; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        vectors++; if (skew_q.size() !== s0 + 1 || onerdy_q.size() <= o0) begin miscompares++; $display("FAIL skew_pulse_count: got %0d expected 1", skew_q.size() - s0); end
        else begin
            vectors++; if (skew_q[s0] - onerdy_q[o0] !== ST) begin miscompares++; $display("FAIL skew_delay: got %0d expected %0d", skew_q[s0] - onerdy_q[o0], ST); end
        end
        vectors++; if (ra_cnt - ca !== FL || rb_cnt - cb !== 0) begin miscompares++; $display("FAIL skew_flush_reads: got %0d/%0d expected %0d/0", ra_cnt - ca, rb_cnt - cb, FL); end
        vectors++; if (f.a_rdempty !== 1'b1 || f.a_rdusedw !== '0) begin miscompares++; $display("FAIL skew_a_empty: got %b/%0d expected 1/0", f.a_rdempty, f.a_rdusedw); end
        vectors++; if (int'(skew_events) !== 1 || done_q.size() !== n0) begin miscompares++; $display("FAIL skew_stats: got events=%0d frames=%0d expected 1/0", skew_events, done_q.size() - n0); end
    endtask

    task automatic test_back_to_back();
        frame_t a; int n0; bit ok;
        do_reset();
        n0 = done_q.size();
        for (int k = 0; k < 3; k++) begin rand_frame(a); push_frame(a, a, 1, 1); end
        enable = 1;
        wait_done(n0 + 3, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_done_timeout: frames got %0d expected 3", done_q.size() - n0); end
        else begin
            for (int k = 1; k < 3; k++) begin
                vectors++; if (done_q[n0+k].cyc - done_q[n0+k-1].cyc !== FL + 3) begin miscompares++; $display("FAIL b2b_period: got %0d expected %0d", done_q[n0+k].cyc - done_q[n0+k-1].cyc, FL + 3); end
            end
            for (int k = 0; k < 3; k++) begin
                vectors++; if (done_q[n0+k].match !== 1 || done_q[n0+k].tot !== k + 1) begin miscompares++; $display("FAIL b2b_frame: got match=%0d tot=%0d expected 1/%0d", done_q[n0+k].match, done_q[n0+k].tot, k + 1); end
            end
        end
    endtask

    task automatic test_enable_drop();
        frame_t a; int n0, ca; bit ok;
        do_reset();
        rand_frame(a);
        n0 = done_q.size();
        push_frame(a, a, 1, 1);
        enable = 1;
        wait_rdreq(50, ok);
        repeat (4) @(negedge clk);
        enable = 0;
        wait_done(n0 + 1, 100, ok);
        vectors++; if (!ok || done_q[n0].match !== 1) begin miscompares++; $display("FAIL en_drop_frame: got frames=%0d expected 1 matching", done_q.size() - n0); end
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL en_drop_idle: busy got %b expected 0", busy); end
        ca = ra_cnt;
        push_frame(a, a, 1, 1);
        repeat (30) @(negedge clk);
        vectors++; if (ra_cnt !== ca || busy !== 1'b0) begin miscompares++; $display("FAIL en_off_reads: got %0d reads busy=%b expected 0/0", ra_cnt - ca, busy); end
    endtask

    task automatic test_reset_mid_read();
        frame_t a, b; int n0; bit ok;
        do_reset();
        rand_frame(a); b = a; b[3] = ~a[3];
        n0 = done_q.size();
        push_frame(a, b, 1, 1);
        enable = 1;
        wait_done(n0 + 1, 100, ok);
        push_frame(a, b, 1, 1);
        wait_rdreq(50, ok);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        vectors++; if ({busy, f.a_rdreq, f.b_rdreq, frame_done, frame_match, skew_err} !== 6'b0) begin miscompares++; $display("FAIL rst_mid_flags: got %b expected 000000", {busy, f.a_rdreq, f.b_rdreq, frame_done, frame_match, skew_err}); end
        vectors++; if (frame_mis_cnt !== '0 || first_mis_idx !== '0 || {first_mis_a, first_mis_b} !== 16'h0) begin miscompares++; $display("FAIL rst_mid_result: got %0d %0d %h expected 0 0 0000", frame_mis_cnt, first_mis_idx, {first_mis_a, first_mis_b}); end
        vectors++; if ({frames_total, frames_bad, skew_events} !== 6'b0) begin miscompares++; $display("FAIL rst_mid_stats: got %b expected 000000", {frames_total, frames_bad, skew_events}); end
        enable = 0;
        wr_a = rd_a; wr_b = rd_b;
        @(negedge clk);
        rst = 0;
        n0 = done_q.size();
        repeat (30) @(negedge clk);
        vectors++; if (done_q.size() !== n0) begin miscompares++; $display("FAIL rst_mid_no_report: got %0d frames expected 0", done_q.size() - n0); end
    endtask

    task automatic test_saturation();
        frame_t a, b; int n0; bit ok;
        do_reset();
        n0 = done_q.size();
        for (int k = 0; k < 5; k++) begin
            rand_frame(a); b = a; b[k] = a[k] ^ 8'h5A;
            push_frame(a, b, 1, 1);
        end
        enable = 1;
        wait_done(n0 + 5, 400, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sat_done_timeout: frames got %0d expected 5", done_q.size() - n0); end
        else begin
            for (int k = 0; k < 5; k++) begin
                vectors++; if (done_q[n0+k].tot !== ((k + 1 < STAT_MAX) ? k + 1 : STAT_MAX) || done_q[n0+k].bad !== ((k + 1 < STAT_MAX) ? k + 1 : STAT_MAX)) begin miscompares++; $display("FAIL sat_stats: got %0d/%0d after frame %0d", done_q[n0+k].tot, done_q[n0+k].bad, k + 1); end
            end
        end
    endtask

    task automatic test_random();
        frame_t a, b; int n0, mis, idx, fa, fb, nbad, exp_tot, exp_bad; bit ok; rec_t r;
        do_reset();
        enable = 1;
        nbad = 0;
        for (int k = 0; k < 8; k++) begin
            rand_frame(a); b = a;
            if ($urandom_range(0, 3) != 0)
                for (int i = 0; i < FL; i++)
                    if ($urandom_range(0, 3) == 0) b[i] = a[i] ^ 8'($urandom_range(1, 255));
            ref_frame(a, b, mis, idx, fa, fb);
            if (mis != 0) nbad++;
            n0 = done_q.size();
            push_frame(a, b, 1, 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            push_frame(a, b, 0, 1);
            wait_done(n0 + 1, 200, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_done_timeout: frame %0d not reported", k); end
            else begin
                r = done_q[n0];
                exp_tot = (k + 1 < STAT_MAX) ? k + 1 : STAT_MAX;
                exp_bad = (nbad < STAT_MAX) ? nbad : STAT_MAX;
                vectors++; if (r.match !== int'(mis == 0) || r.mis !== mis || r.idx !== idx || r.fa !== fa || r.fb !== fb) begin miscompares++; $display("FAIL rnd_verdict: got %0d/%0d/%0d/%0h/%0h expected %0d/%0d/%0d/%0h/%0h", r.match, r.mis, r.idx, r.fa, r.fb, int'(mis == 0), mis, idx, fa, fb); end
                vectors++; if (r.tot !== exp_tot || r.bad !== exp_bad) begin miscompares++; $display("FAIL rnd_stats: got %0d/%0d expected %0d/%0d", r.tot, r.bad, exp_tot, exp_bad); end
                vectors++; if (r.cyc - rise_q[rise_q.size()-1] !== FL + 1) begin miscompares++; $display("FAIL rnd_latency: got %0d expected %0d", r.cyc - rise_q[rise_q.size()-1], FL + 1); end
            end
        end
    endtask

    initial begin
        rst = 1;
        enable = 0;
        test_reset();
        test_equal_frame();
        test_mismatch();
        test_skew();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_read();
        test_saturation();
        test_random();
        vectors++; if (underflows !== 0) begin miscompares++; $display("FAIL fifo_underflow: got %0d expected 0", underflows); end
        vectors++; if (long_done !== 0 || long_skew !== 0) begin miscompares++; $display("FAIL pulse_width: got %0d/%0d multi-cycle pulses expected 0/0", long_done, long_skew); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
